// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine with HI/LO registers.
// Operands are latched as magnitudes; signs are restored in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mcand;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             dz;

    logic               idle;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     cur_rem;
    logic [WIDTH-1:0]   cur_quo;
    logic [WIDTH-1:0]   cur_m;
    logic               cur_div;
    logic [WIDTH:0]     nxt_rem;
    logic [WIDTH-1:0]   nxt_quo;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;

    assign idle  = (state == IDLE);
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // The accepting edge already performs the first iteration from the
    // raw operands, so RUN only needs WIDTH-1 further edges.
    assign cur_rem = idle ? '0 : rem;
    assign cur_quo = idle ? (op[1] ? mag_a : mag_b) : quo;
    assign cur_m   = idle ? (op[1] ? mag_b : mag_a) : mcand;
    assign cur_div = idle ? op[1] : is_div;
    assign prod    = {rem[WIDTH-1:0], quo};

    always_comb begin
        sum     = '0;
        shl     = '0;
        diff    = '0;
        nxt_rem = cur_rem;
        nxt_quo = cur_quo;
        if (cur_div) begin
            shl     = {cur_rem[WIDTH-1:0], cur_quo[WIDTH-1]};
            diff    = {1'b0, shl} - {2'b00, cur_m};
            nxt_rem = diff[WIDTH+1] ? shl : diff[WIDTH:0];
            nxt_quo = {cur_quo[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
            sum     = cur_rem
                    + {1'b0, (cur_quo[0] ? cur_m : {WIDTH{1'b0}})};
            nxt_rem = {1'b0, sum[WIDTH:1]};
            nxt_quo = {sum[0], cur_quo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            mcand       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz          <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        mcand   <= cur_m;
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if (op[1] && b == '0) begin
                            // Keep the raw dividend: it becomes HI.
                            quo   <= a;
                            dz    <= 1'b1;
                            state <= FIX;
                        end else begin
                            rem   <= nxt_rem;
                            quo   <= nxt_quo;
                            state <= RUN;
                        end
                    end else if (start && op[1:0] == 2'b00) begin
                        hi <= a;
                    end else if (start && op[1:0] == 2'b01) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    rem <= nxt_rem;
                    quo <= nxt_quo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        hi <= quo;
                        lo <= '1;
                    end else if (is_div) begin
                        lo <= neg_res ? -quo : quo;
                        hi <= neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= neg_res ? -prod : prod;
                    end
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    dz          <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
